nco_sweep_ctrl: RTL

Sequencer for the NCO. On `start` it latches a sweep configuration, then runs the NCO through a stepped-frequency sweep:
- programs `phi_inc_i`, drives the NCO's active-low reset and `clken`;
- after each frequency change, waits for the NCO pipeline to settle;
- qualifies a fixed number of valid output samples per step ("dwell") for the downstream capture/FIR path.

It sits between the register/control interface and the NCO instance.

---
 rtl/nco_sweep_ctrl_if.sv | 36 +++
 rtl/nco_sweep_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl_if.sv
// Control/NCO-side bundle for nco_sweep_ctrl: sweep configuration and
// start/stop on one side, NCO phase-increment, clock-enable and reset on the other.
interface nco_sweep_ctrl_if #(
    parameter int PHI_W = 32,
    parameter int CNT_W = 16
);
    logic             start;
    logic             stop;
    logic [PHI_W-1:0] cfg_phi_start;
    logic [PHI_W-1:0] cfg_phi_step;
    logic [CNT_W-1:0] cfg_num_steps;
    logic [CNT_W-1:0] cfg_dwell;
    logic             nco_out_valid;
    logic [PHI_W-1:0] nco_phi_inc;
    logic             nco_clken;
    logic             nco_reset_n;
    logic             sample_valid;
    logic             sample_last;
    logic [CNT_W-1:0] step_idx;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, cfg_phi_start, cfg_phi_step, cfg_num_steps, cfg_dwell,
        output nco_out_valid,
        input  nco_phi_inc, nco_clken, nco_reset_n, sample_valid, sample_last,
        input  step_idx, busy, done
    );

    modport slave (
        input  start, stop, cfg_phi_start, cfg_phi_step, cfg_num_steps, cfg_dwell,
        input  nco_out_valid,
        output nco_phi_inc, nco_clken, nco_reset_n, sample_valid, sample_last,
        output step_idx, busy, done
    );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep sequencer for the NCO (reset, settle, dwell per step).
// Define NCO_SWEEP_LOOP_EN to make the sweep repeat from phi_start until stop.
module nco_sweep_ctrl #(
    parameter int PHI_W      = 32,
    parameter int CNT_W      = 16,
    parameter int RST_CYC    = 8,
    parameter int SETTLE_CYC = 6
) (
    input  logic            clk,
    input  logic            reset,
    nco_sweep_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RST    = 3'd1,
        S_SETTLE = 3'd2,
        S_DWELL  = 3'd3,
        S_NEXT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           r_state;
    logic [PHI_W-1:0] r_phi_inc;
    logic [PHI_W-1:0] r_phi_start;
    logic [PHI_W-1:0] r_phi_step;
    logic [CNT_W-1:0] r_last_idx;
    logic [CNT_W-1:0] r_dwell_last;
    logic [CNT_W-1:0] r_step_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clken;
    logic             r_reset_n;
    logic             r_busy;
    logic             r_done;

    logic             w_sample_valid;
    logic             w_sample_last;
    logic             w_start_ok;

    // Samples are qualified combinationally so they line up with the NCO data word.
    assign w_sample_valid = (r_state == S_DWELL) && bus.nco_out_valid;
    assign w_sample_last  = w_sample_valid && (r_cnt == r_dwell_last);
    assign w_start_ok     = bus.start && !bus.stop;

    assign bus.nco_phi_inc  = r_phi_inc;
    assign bus.nco_clken    = r_clken;
    assign bus.nco_reset_n  = r_reset_n;
    assign bus.sample_valid = w_sample_valid;
    assign bus.sample_last  = w_sample_last;
    assign bus.step_idx     = r_step_idx;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;

    // Sweep sequencer state machine with registered NCO controls and status.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_phi_inc    <= {PHI_W{1'b0}};
            r_phi_start  <= {PHI_W{1'b0}};
            r_phi_step   <= {PHI_W{1'b0}};
            r_last_idx   <= {CNT_W{1'b0}};
            r_dwell_last <= {CNT_W{1'b0}};
            r_step_idx   <= {CNT_W{1'b0}};
            r_cnt        <= {CNT_W{1'b0}};
            r_clken      <= 1'b0;
            r_reset_n    <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (bus.stop && (r_state != S_IDLE)) begin
            // Abort: phi_inc is left as-is so software can read where it stopped.
            r_state   <= S_IDLE;
            r_cnt     <= {CNT_W{1'b0}};
            r_clken   <= 1'b0;
            r_reset_n <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_phi_start  <= bus.cfg_phi_start;
                        r_phi_step   <= bus.cfg_phi_step;
                        r_last_idx   <= bus.cfg_num_steps - CNT_W'(1);
                        r_dwell_last <= (bus.cfg_dwell == {CNT_W{1'b0}}) ?
                                        {CNT_W{1'b0}} : (bus.cfg_dwell - CNT_W'(1));
                        r_step_idx   <= {CNT_W{1'b0}};
                        r_cnt        <= {CNT_W{1'b0}};
                        r_busy       <= 1'b1;
                        if (bus.cfg_num_steps == {CNT_W{1'b0}}) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_phi_inc <= bus.cfg_phi_start;
                            r_reset_n <= 1'b0;
                            r_clken   <= 1'b1;
                            r_state   <= S_RST;
                        end
                    end
                end
                S_RST: begin
                    if (r_cnt == CNT_W'(RST_CYC - 1)) begin
                        r_cnt     <= {CNT_W{1'b0}};
                        r_reset_n <= 1'b1;
                        r_state   <= S_SETTLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    // Only cycles the NCO actually advanced count toward its latency.
                    if (bus.nco_out_valid) begin
                        if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                            r_cnt   <= {CNT_W{1'b0}};
                            r_state <= S_DWELL;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DWELL: begin
                    if (w_sample_last) begin
                        r_cnt   <= {CNT_W{1'b0}};
                        r_state <= S_NEXT;
                    end else if (w_sample_valid) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_NEXT: begin
                    if (r_step_idx == r_last_idx) begin
`ifdef NCO_SWEEP_LOOP_EN
                        r_phi_inc  <= r_phi_start;
                        r_step_idx <= {CNT_W{1'b0}};
                        r_done     <= 1'b1;
                        r_state    <= S_SETTLE;
`else
                        r_clken <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
`endif
                    end else begin
                        r_phi_inc  <= r_phi_inc + r_phi_step;
                        r_step_idx <= r_step_idx + CNT_W'(1);
                        r_state    <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_clken <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_clken   <= 1'b0;
                    r_reset_n <= 1'b1;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
